// File: rtl/data_memory.sv
// data_memory
//   Word-organised data memory serving the core's data port, with a second
//   handshaked debug port for preload/dump while the core runs.
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous active-low reset
//     cpu_addr     byte address from the core
//     cpu_rd_wr    1 = read (idle default), 0 = write
//     cpu_wdata    store data from the core
//     cpu_rdata    registered read data (1-cycle latency, 0 on writes/invalid)
//     addr_err     sticky misaligned / out-of-range CPU access flag
//     dbg_valid    debug request valid
//     dbg_ready    debug request accepted when high with dbg_valid
//     dbg_wr       1 = debug write, 0 = debug read
//     dbg_addr     debug word index
//     dbg_wdata    debug write data
//     dbg_rdata    debug read data, held while dbg_rvalid
//     dbg_rvalid   debug read response valid, held until dbg_rready
//     dbg_rready   debug read response consumed
//     rd_count     (DATA_MEMORY_ACCESS_COUNT_EN only) saturating valid-read count
//     wr_count     (DATA_MEMORY_ACCESS_COUNT_EN only) saturating valid-write count
//
//   Optional feature macro: DATA_MEMORY_ACCESS_COUNT_EN

module data_memory #(
    parameter logic [31:0] base_addr = 32'h0000_0000,
    parameter int          depth     = 1024,
    parameter int          aw        = $clog2(depth)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   cpu_addr,
    input  logic          cpu_rd_wr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          addr_err,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic          dbg_wr,
    input  logic [aw-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_rvalid,
    input  logic          dbg_rready
`ifdef DATA_MEMORY_ACCESS_COUNT_EN
    ,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } dbg_state_e;

    logic [31:0]   mem [depth];

    dbg_state_e    state_q, state_d;
    logic [aw-1:0] dbgAddr_q, dbgAddr_d;
    logic [31:0]   dbgRdata_q;
    logic [31:0]   cpuRdata_q;
    logic          addrErr_q;

    // Word offset from the base; base is word aligned so the byte-lane bits
    // never take part in the subtraction.
    logic [29:0]   cpuWordOff;
    logic [aw-1:0] cpuIdx;
    logic          cpuValid;
    logic          cpuWrEn;
    logic          dbgWrEn;

    assign cpuWordOff = cpu_addr[31:2] - base_addr[31:2];
    assign cpuIdx     = cpuWordOff[aw-1:0];
    assign cpuValid   = (cpu_addr[1:0] == 2'b00) && (cpuWordOff[29:aw] == '0);
    assign cpuWrEn    = cpuValid && !cpu_rd_wr;
    assign dbgWrEn    = (state_q == IDLE) && dbg_valid && dbg_wr;

    assign cpu_rdata  = cpuRdata_q;
    assign addr_err   = addrErr_q;
    assign dbg_rdata  = dbgRdata_q;
    assign dbg_rvalid = (state_q == RESP);

    // Debug FSM next-state: writes complete in IDLE, reads take a sample
    // cycle (READ) then hold the response (RESP) until consumed.
    always_comb begin
        state_d   = state_q;
        dbgAddr_d = dbgAddr_q;
        dbg_ready = 1'b0;
        case (state_q)
            IDLE: begin
                dbg_ready = 1'b1;
                if (dbg_valid && !dbg_wr) begin
                    dbgAddr_d = dbg_addr;
                    state_d   = READ;
                end
            end
            READ: state_d = RESP;
            RESP: begin
                if (dbg_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory array is never cleared. Writes are suppressed while reset is
    // asserted. The CPU write is ordered last so it wins a same-word collision.
    always_ff @(posedge clk or negedge reset) begin
        if (reset) begin
            if (dbgWrEn) begin
                mem[dbg_addr] <= dbg_wdata;
            end
            if (cpuWrEn) begin
                mem[cpuIdx] <= cpu_wdata;
            end
        end
    end

    // Read ports, sticky error and debug FSM state. Reads sample the array
    // before this edge's writes land, so a same-edge debug read sees old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dbgAddr_q  <= '0;
            dbgRdata_q <= '0;
            cpuRdata_q <= '0;
            addrErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbgAddr_q <= dbgAddr_d;
            if (state_q == READ) begin
                dbgRdata_q <= mem[dbgAddr_q];
            end
            cpuRdata_q <= (cpu_rd_wr && cpuValid) ? mem[cpuIdx] : '0;
            if (!cpuValid) begin
                addrErr_q <= 1'b1;
            end
        end
    end

`ifdef DATA_MEMORY_ACCESS_COUNT_EN
    logic [31:0] rdCount_q;
    logic [31:0] wrCount_q;

    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;

    // Saturating access counters; an idle cycle (rd_wr=1) is a read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else if (cpuValid) begin
            if (cpu_rd_wr) begin
                if (rdCount_q != 32'hFFFF_FFFF) begin
                    rdCount_q <= rdCount_q + 32'd1;
                end
            end else begin
                if (wrCount_q != 32'hFFFF_FFFF) begin
                    wrCount_q <= wrCount_q + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
//   Self-checking bench for data_memory. CPU operations come from vector
//   tables; expected CPU and debug responses go through scoreboard queues.
//   Honours DATA_MEMORY_ACCESS_COUNT_EN for the optional counters.

module tb_data_memory;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 1024;
    localparam int          AW    = $clog2(DEPTH);

    typedef struct {
        logic        rdWr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
    } cpuVec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } cpuExp_t;

    logic          clk;
    logic          reset;
    logic [31:0]   cpu_addr;
    logic          cpu_rd_wr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          addr_err;
    logic          dbg_valid;
    logic          dbg_ready;
    logic          dbg_wr;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [31:0]   dbg_rdata;
    logic          dbg_rvalid;
    logic          dbg_rready;
`ifdef DATA_MEMORY_ACCESS_COUNT_EN
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
`endif

    int errors = 0;
    int checks = 0;

    cpuExp_t     cpuQ[$];
    logic [31:0] dbgQ[$];

    data_memory #(
        .base_addr (BASE),
        .depth     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_rd_wr  (cpu_rd_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .addr_err   (addr_err),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rready (dbg_rready)
`ifdef DATA_MEMORY_ACCESS_COUNT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpuIdle();
        cpu_rd_wr = 1'b1;
        cpu_addr  = BASE;
        cpu_wdata = '0;
    endtask

    // Starts and ends on a falling edge; result sampled 1 time unit after the edge.
    task automatic applyStimulus(input string name, input cpuVec_t v);
        cpuExp_t e;
        cpu_rd_wr = v.rdWr;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpuQ.push_back('{rdata: v.expRdata, err: v.expErr});
        @(posedge clk);
        #1;
        if (cpuQ.size() == 0) begin
            checkOutput({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = cpuQ.pop_front();
            checkOutput({name, " rdata"}, cpu_rdata, e.rdata);
            checkOutput({name, " addr_err"}, {31'd0, addr_err}, {31'd0, e.err});
        end
        @(negedge clk);
    endtask

    task automatic dbgWrite(input logic [AW-1:0] idx, input logic [31:0] data);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b1;
        dbg_addr  = idx;
        dbg_wdata = data;
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        dbg_wr    = 1'b0;
        @(negedge clk);
    endtask

    task automatic dbgRead(input string name, input logic [AW-1:0] idx,
                           input logic [31:0] exp, input int hold);
        logic [31:0] e;
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = idx;
        dbgQ.push_back(exp);
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        checkOutput({name, " ready in READ"}, {31'd0, dbg_ready}, 32'd0);
        checkOutput({name, " rvalid in READ"}, {31'd0, dbg_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        e = dbgQ.pop_front();
        checkOutput({name, " rvalid"}, {31'd0, dbg_rvalid}, 32'd1);
        checkOutput({name, " rdata"}, dbg_rdata, e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({name, " rvalid held"}, {31'd0, dbg_rvalid}, 32'd1);
            checkOutput({name, " rdata held"}, dbg_rdata, e);
            checkOutput({name, " ready held low"}, {31'd0, dbg_ready}, 32'd0);
        end
        dbg_rready = 1'b1;
        @(posedge clk);
        #1;
        dbg_rready = 1'b0;
        checkOutput({name, " rvalid cleared"}, {31'd0, dbg_rvalid}, 32'd0);
        checkOutput({name, " ready back"}, {31'd0, dbg_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        cpuVec_t basic [9];
        cpuVec_t errVecs [5];
        cpuVec_t cntVecs [6];

        basic[0] = '{1'b0, BASE + 32'h0,   32'h1111_1111, 32'h0,          1'b0};
        basic[1] = '{1'b1, BASE + 32'h0,   32'h0,         32'h1111_1111, 1'b0};
        basic[2] = '{1'b0, BASE + 32'h8,   32'hDEAD_BEEF, 32'h0,          1'b0};
        basic[3] = '{1'b1, BASE + 32'h8,   32'h0,         32'hDEAD_BEEF, 1'b0};
        basic[4] = '{1'b0, BASE + 32'hFFC, 32'hCAFE_F00D, 32'h0,          1'b0};
        basic[5] = '{1'b1, BASE + 32'hFFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        basic[6] = '{1'b1, BASE + 32'h0,   32'h0,         32'h1111_1111, 1'b0};
        basic[7] = '{1'b0, BASE + 32'h4,   32'h55AA_55AA, 32'h0,          1'b0};
        basic[8] = '{1'b1, BASE + 32'h4,   32'h0,         32'h55AA_55AA, 1'b0};

        errVecs[0] = '{1'b0, BASE + 32'h2,    32'h0000_0099, 32'h0,          1'b1};
        errVecs[1] = '{1'b1, BASE + 32'h0,    32'h0,         32'h1111_1111, 1'b1};
        errVecs[2] = '{1'b1, BASE + 32'h1000, 32'h0,         32'h0,          1'b1};
        errVecs[3] = '{1'b1, BASE - 32'h4,    32'h0,         32'h0,          1'b1};
        errVecs[4] = '{1'b1, BASE + 32'h8,    32'h0,         32'h0BAD_F00D, 1'b1};

        cntVecs[0] = '{1'b0, BASE + 32'h10, 32'h0000_0016, 32'h0,          1'b0};
        cntVecs[1] = '{1'b0, BASE + 32'h1C, 32'h0000_001C, 32'h0,          1'b0};
        cntVecs[2] = '{1'b1, BASE + 32'h10, 32'h0,         32'h0000_0016, 1'b0};
        cntVecs[3] = '{1'b1, BASE + 32'h1C, 32'h0,         32'h0000_001C, 1'b0};
        cntVecs[4] = '{1'b1, BASE + 32'h18, 32'h0,         32'h6666_6666, 1'b0};
        cntVecs[5] = '{1'b1, BASE + 32'h14, 32'h0,         32'h1234_5678, 1'b0};

        reset      = 1'b0;
        dbg_valid  = 1'b0;
        dbg_wr     = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
        dbg_rready = 1'b0;
        cpuIdle();

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("reset addr_err", {31'd0, addr_err}, 32'd0);
        checkOutput("reset dbg_ready", {31'd0, dbg_ready}, 32'd1);
        checkOutput("reset dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        checkOutput("reset dbg_rdata", dbg_rdata, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("basic[%0d]", i), basic[i]);
        end
        cpuIdle();

        // Debug write visible to CPU, then a held debug read response
        dbgWrite(AW'(5), 32'h1234_5678);
        applyStimulus("cpu read dbg word", '{1'b1, BASE + 32'h14, 32'h0, 32'h1234_5678, 1'b0});
        cpuIdle();
        dbgRead("dbg read idx5", AW'(5), 32'h1234_5678, 3);
        dbgRead("dbg read idx1023", AW'(1023), 32'hCAFE_F00D, 0);

        // Same-edge CPU and debug writes to one word: CPU wins
        cpu_rd_wr = 1'b0;
        cpu_addr  = BASE + 32'hC;
        cpu_wdata = 32'h0000_000A;
        dbg_valid = 1'b1;
        dbg_wr    = 1'b1;
        dbg_addr  = AW'(3);
        dbg_wdata = 32'h0000_000B;
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        dbg_wr    = 1'b0;
        cpuIdle();
        @(negedge clk);
        dbgRead("write collision", AW'(3), 32'h0000_000A, 0);

        // Debug read sample on the same edge as a CPU write returns old data
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = AW'(2);
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        @(negedge clk);
        cpu_rd_wr = 1'b0;
        cpu_addr  = BASE + 32'h8;
        cpu_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        checkOutput("read-vs-write old data", dbg_rdata, 32'hDEAD_BEEF);
        cpuIdle();
        dbg_rready = 1'b1;
        @(posedge clk);
        #1;
        dbg_rready = 1'b0;
        @(negedge clk);
        applyStimulus("cpu sees new word2", '{1'b1, BASE + 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0});

        // Invalid accesses: dropped write, zero reads, sticky error
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("errVecs[%0d]", i), errVecs[i]);
        end
        cpuIdle();

        // Reset while the debug FSM holds a response
        dbgWrite(AW'(6), 32'h6666_6666);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = AW'(5);
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre-reset rvalid", {31'd0, dbg_rvalid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid-reset rvalid", {31'd0, dbg_rvalid}, 32'd0);
        checkOutput("mid-reset ready", {31'd0, dbg_ready}, 32'd1);
        checkOutput("mid-reset dbg_rdata", dbg_rdata, 32'd0);
        checkOutput("mid-reset addr_err", {31'd0, addr_err}, 32'd0);

        // A CPU write held across reset edges must not land
        @(negedge clk);
        cpu_rd_wr = 1'b0;
        cpu_addr  = BASE + 32'h18;
        cpu_wdata = 32'h0000_0BAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("cntVecs[%0d]", i), cntVecs[i]);
        end
`ifdef DATA_MEMORY_ACCESS_COUNT_EN
        checkOutput("rd_count", rd_count, 32'd4);
        checkOutput("wr_count", wr_count, 32'd2);
`endif
        cpuIdle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory that acts as the responder on the processor's data-memory port. It accepts the core's address, read/write select and store data.
- Reads return data with a fixed 1-cycle latency, aligned with the core's writeback stage.
- A second, handshaked debug port lets the bench preload and dump memory while the core runs.
- Sits beside the core at top level; its CPU read data drives the core's data input.

Parameters:
- base_addr, 32'h0000_0000, byte address of word 0; must be word aligned.
- depth, 1024, number of 32-bit words; must be a power of two, at least 2.
- aw, $clog2(depth), word-index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous active-low reset.
- cpu_addr  input  32  byte address from the core.
- cpu_rd_wr  input  1  1 = read (idle default), 0 = write.
- cpu_wdata  input  32  store data from the core.
- cpu_rdata  output  32  registered read data to the core.
- addr_err  output  1  sticky flag for misaligned or out-of-range CPU access.
- dbg_valid  input  1  debug request valid.
- dbg_ready  output  1  debug request accepted when high together with dbg_valid.
- dbg_wr  input  1  1 = debug write, 0 = debug read.
- dbg_addr  input  aw  debug word index.
- dbg_wdata  input  32  debug write data.
- dbg_rdata  output  32  debug read data.
- dbg_rvalid  output  1  dbg_rdata valid; held until dbg_rready.
- dbg_rready  input  1  debug read response consumed.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - cpu_rdata=0, addr_err=0, dbg_rdata=0, dbg_rvalid=0, dbg_ready=1, debug FSM to IDLE.
  - Memory contents are not cleared.
- CPU address check:
  - offset = cpu_addr - base_addr (32-bit wrap).
  - Access is valid iff cpu_addr[1:0]==0 and offset[31:2] < depth; word index = offset[aw+1:2].
- CPU read (cpu_rd_wr=1): at edge N, cpu_rdata <= mem[index] if valid, else 0. cpu_rdata is stable until edge N+1.
- CPU write (cpu_rd_wr=0): at edge N, mem[index] <= cpu_wdata if valid; invalid writes are dropped. cpu_rdata <= 0 during a write cycle.
- Read-after-write: a read at edge N+1 of a word written at edge N returns the new data.
- addr_err: set on the edge after any invalid access, read or write. Cleared only by reset.
- Debug FSM states:
  - IDLE: dbg_ready=1.
    - On dbg_valid&&dbg_ready with dbg_wr=1: write mem[dbg_addr], stay in IDLE.
    - On dbg_valid&&dbg_ready with dbg_wr=0: latch the address, go to READ.
  - READ: dbg_ready=0. dbg_rdata <= mem[latched addr], dbg_rvalid <= 1, go to RESP.
  - RESP: dbg_ready=0, dbg_rvalid=1, dbg_rdata held. On dbg_rready go to IDLE and clear dbg_rvalid on the same edge.
  - Read latency from accept to dbg_rvalid=1 is 2 edges.
- Collisions:
  - CPU write and debug write to the same word on the same edge: CPU data wins.
  - CPU write and debug READ sample of the same word on the same edge: debug returns the old data.
  - Any other concurrent accesses proceed independently (true dual-port).
- Reset mid-transaction: a pending debug read is aborted with no response; a CPU write on the reset edge is not performed.

Optional Feature:
- Macro DATA_MEMORY_ACCESS_COUNT_EN.
- When defined, adds outputs rd_count[31:0] and wr_count[31:0]:
  - Counts valid CPU reads and valid CPU writes respectively.
  - Saturate at 32'hFFFF_FFFF; reset to 0.
  - A cycle with cpu_rd_wr=1 counts as a read every cycle.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then hold cpu_rd_wr=1, cpu_addr=base_addr -> cpu_rdata=0 on reset, then mem[0]; addr_err=0, dbg_ready=1.
- CPU write 32'hDEADBEEF to base_addr+8, then read base_addr+8 on the next cycle -> cpu_rdata=32'hDEADBEEF one edge after the read.
- CPU write to base_addr+2, then read base_addr+depth*4 -> write dropped, read returns 0, addr_err=1 and stays 1 until reset.
- Debug write 32'h1234_5678 to index 5, CPU read base_addr+20 -> 32'h1234_5678. Then debug read index 5 with dbg_rready held low 3 cycles -> dbg_rvalid stays 1, data stable, dbg_ready=0 until consumed.
- Same-edge CPU write 32'hA and debug write 32'hB to index 3, then debug read index 3 -> 32'hA.
- Assert reset while the debug FSM is in RESP -> dbg_rvalid=0 and dbg_ready=1 immediately. With DATA_MEMORY_ACCESS_COUNT_EN: 4 valid reads and 2 valid writes give rd_count=4, wr_count=2.
